i2c_master_bus_condition: RTL and testbench
===========================================

Name: i2c_master_bus_condition

Overview:
Parametrised I2C master bus-condition generator that produces START, repeated START (RESTART) and STOP on open-drain SDA/SCL from a single command interface. It has programmable timing, clock-stretch timeout, arbitration-loss detection and input synchronisation. It sits between the I2C master byte engine and the pad open-drain drivers, and it replaces the separate per-condition sequencers.

Parameters:
HALF_PERIOD, 250, clk cycles per bus phase (e.g. 50 MHz / 100 kHz / 2); legal range 2..65535.
STRETCH_TIMEOUT, 5000, max clk cycles spent waiting for SCL high before abort; legal range 1..2^24-1.
FILTER_LEN, 3, consecutive equal samples needed to accept an input change; used only with I2C_SPIKE_FILTER_EN.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid & cmd_ready
cmd  in  2  00 START, 01 RESTART, 10 STOP, 11 reserved
done  out  1  one-cycle pulse at command completion
status  out  2  00 OK, 01 STRETCH_TIMEOUT, 10 ARB_LOST, 11 BAD_CMD; valid with done, held until next accept
busy  out  1  high from accept until done, inclusive
sda_in  in  1  raw SDA pad level
scl_in  in  1  raw SCL pad level
sda_oe  out  1  1 = drive SDA low, 0 = release
scl_oe  out  1  1 = drive SCL low, 0 = release

Behaviour:
- Reset (asynchronous): sda_oe=0, scl_oe=0, done=0, status=00, busy=0, state IDLE, all counters 0. Reset mid-command releases both lines immediately. No done is generated for the aborted command.
- sda_in and scl_in pass through 2-flop synchronisers (sda_s, scl_s). All checks use the synchronised values.
- "Wait T" means a phase counter is loaded with HALF_PERIOD-1 and counts down to 0, so the phase lasts exactly HALF_PERIOD cycles.
- WAIT_SCL: scl_oe=0. The block stays in this state until scl_s=1, then leaves on the next edge; minimum 1 cycle.
  - A stretch counter increments each cycle in this state.
  - When the counter reaches STRETCH_TIMEOUT: release both lines, status=01, done.
  - If scl_s=1 on the same cycle the limit is reached, scl_s wins and there is no timeout.
- START (bus idle expected):
  - S0: release both lines, wait T. At the end, if sda_s=0 or scl_s=0: status=10, done.
  - S1: sda_oe=1, wait T.
  - S2: scl_oe=1, wait T.
  - Done, status OK. Both lines are left driven low.
- RESTART (SCL driven low on entry):
  - R0: sda_oe=0, scl_oe=1, wait T.
  - R1: WAIT_SCL.
  - R2: wait T. At the end, if sda_s=0: ARB_LOST.
  - R3: sda_oe=1, wait T.
  - R4: scl_oe=1, wait T.
  - Done, status OK.
- STOP:
  - P0: sda_oe=1, scl_oe=1, wait T.
  - P1: WAIT_SCL.
  - P2: wait T.
  - P3: sda_oe=0, wait T. At the end, if sda_s=0: ARB_LOST.
  - Done, status OK. Both lines are left released.
- ARB_LOST or timeout: sda_oe=0 and scl_oe=0 in the cycle done is asserted. No further phases run.
- BAD_CMD (cmd=11): done one cycle after accept, status=11, lines unchanged.
- Latency from the accept edge to done, with no stretch and no filter:
  - START: 3*HALF_PERIOD.
  - RESTART: 4*HALF_PERIOD+3.
  - STOP: 3*HALF_PERIOD+3.
  - Each added stretch cycle adds 1 to RESTART and STOP.
- The cycle done is high returns to IDLE; cmd_ready rises in the next cycle. Back-to-back commands are therefore spaced by at least 1 idle cycle.
- cmd_valid while busy is ignored and not queued. cmd is sampled only at accept.

Optional Feature:
I2C_SPIKE_FILTER_EN
- Defined: after the synchroniser, sda_s/scl_s change only after FILTER_LEN consecutive equal samples. This adds FILTER_LEN cycles to each observation, so the RESTART/STOP latency constant grows by FILTER_LEN. Pulses shorter than FILTER_LEN cycles are suppressed.
- Undefined: no filter logic; synchroniser output is used directly.

Test Plan:
- HALF_PERIOD=4, pads pulled up, cmd=START -> sda_oe rises at cycle 4, scl_oe at cycle 8, done at cycle 12, status=00.
- After START, cmd=RESTART, no stretch -> SDA released before SCL; SDA falls while SCL high; done at cycle 19, status=00.
- cmd=STOP, slave holds scl_in=0 for 10 cycles -> done at cycle 25, status=00, both oe=0.
- STRETCH_TIMEOUT=20, cmd=STOP, scl_in held 0 forever -> done 20 cycles after WAIT_SCL entry, status=01, sda_oe=scl_oe=0.
- cmd=RESTART, sda_in forced 0 during R2 -> done at end of R2, status=10, both lines released; cmd=11 -> done next cycle, status=11.
- rst_n asserted low mid-R3 -> sda_oe=scl_oe=0 immediately, no done; after release, cmd_ready=1 and a START completes normally.

Source files
------------

// File: rtl/i2c_master_bus_condition.sv
// i2c_master_bus_condition
// Generates START, repeated START (RESTART) and STOP on open-drain SDA/SCL
// for the I2C master byte engine. It provides programmable phase timing, a
// clock-stretch timeout, arbitration-loss detection and 2-flop input
// synchronisers.
//
// Optional feature: define I2C_SPIKE_FILTER_EN to add a FILTER_LEN-sample
// glitch filter after the synchronisers.
//
// Ports
//   clk, rst_n           system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake, accepted on valid & ready
//   cmd[1:0]             00 START, 01 RESTART, 10 STOP, 11 reserved
//   done                 one-cycle completion pulse
//   status[1:0]          00 OK, 01 STRETCH_TIMEOUT, 10 ARB_LOST, 11 BAD_CMD
//   busy                 accept .. done inclusive
//   sda_in, scl_in       raw pad levels
//   sda_oe, scl_oe       1 = pull line low, 0 = release
module i2c_master_bus_condition #(
  parameter int unsigned HALF_PERIOD     = 250,
  parameter int unsigned STRETCH_TIMEOUT = 5000,
  parameter int unsigned FILTER_LEN      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  output logic       done,
  output logic [1:0] status,
  output logic       busy,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       sda_oe,
  output logic       scl_oe
);

  localparam int unsigned PHASE_W   = 16;
  localparam int unsigned STRETCH_W = 24;

  localparam logic [PHASE_W-1:0]   HP_LOAD   = PHASE_W'(HALF_PERIOD - 1);
  localparam logic [STRETCH_W-1:0] STR_LIMIT = STRETCH_W'(STRETCH_TIMEOUT - 1);

  localparam logic [1:0] CMD_START   = 2'b00;
  localparam logic [1:0] CMD_RESTART = 2'b01;
  localparam logic [1:0] CMD_STOP    = 2'b10;

  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_TIMEOUT = 2'b01;
  localparam logic [1:0] STAT_ARB     = 2'b10;
  localparam logic [1:0] STAT_BAD     = 2'b11;

  // Elaboration-time parameter range checks
  if (HALF_PERIOD < 2 || HALF_PERIOD > 65535) begin : g_bad_half_period
    $error("HALF_PERIOD out of range 2..65535");
  end
  if (STRETCH_TIMEOUT < 1 || STRETCH_TIMEOUT > 24'hFF_FFFF) begin : g_bad_timeout
    $error("STRETCH_TIMEOUT out of range 1..2^24-1");
  end
  if (FILTER_LEN < 1) begin : g_bad_filter
    $error("FILTER_LEN must be at least 1");
  end

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_S0, ST_S1, ST_S2,
    ST_R0, ST_R1, ST_R2, ST_R3, ST_R4,
    ST_P0, ST_P1, ST_P2, ST_P3,
    ST_BAD
  } state_e;

  // --------------------------------------------------------------------------
  // Input synchronisers (reset to the released/idle bus level)
  // --------------------------------------------------------------------------
  logic sda_meta_q, sda_sync_q;
  logic scl_meta_q, scl_sync_q;
  logic sda_s, scl_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
    end else begin
      sda_meta_q <= sda_in;
      sda_sync_q <= sda_meta_q;
      scl_meta_q <= scl_in;
      scl_sync_q <= scl_meta_q;
    end
  end

`ifdef I2C_SPIKE_FILTER_EN
  // Filtered level follows the synchroniser only after FILTER_LEN
  // consecutive samples that differ from the current filtered level.
  localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

  logic             sda_f_q, sda_f_d, scl_f_q, scl_f_d;
  logic [FLT_W-1:0] sda_cnt_q, sda_cnt_d, scl_cnt_q, scl_cnt_d;

  always_comb begin
    sda_f_d   = sda_f_q;
    scl_f_d   = scl_f_q;
    sda_cnt_d = '0;
    scl_cnt_d = '0;
    if (sda_sync_q != sda_f_q) begin
      if (sda_cnt_q == FLT_LAST) begin
        sda_f_d = sda_sync_q;
      end else begin
        sda_cnt_d = sda_cnt_q + FLT_W'(1);
      end
    end
    if (scl_sync_q != scl_f_q) begin
      if (scl_cnt_q == FLT_LAST) begin
        scl_f_d = scl_sync_q;
      end else begin
        scl_cnt_d = scl_cnt_q + FLT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_f_q   <= 1'b1;
      scl_f_q   <= 1'b1;
      sda_cnt_q <= '0;
      scl_cnt_q <= '0;
    end else begin
      sda_f_q   <= sda_f_d;
      scl_f_q   <= scl_f_d;
      sda_cnt_q <= sda_cnt_d;
      scl_cnt_q <= scl_cnt_d;
    end
  end

  assign sda_s = sda_f_q;
  assign scl_s = scl_f_q;
`else
  assign sda_s = sda_sync_q;
  assign scl_s = scl_sync_q;
`endif

  // --------------------------------------------------------------------------
  // Sequencer state
  // --------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [PHASE_W-1:0]     phase_q, phase_d;
  logic [STRETCH_W-1:0]   stretch_q, stretch_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   scl_oe_q, scl_oe_d;
  logic                   done_q, done_d;
  logic [1:0]             status_q, status_d;
  logic                   busy_q, busy_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   phase_end;

  assign phase_end = (phase_q == '0);

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_end ? phase_q : phase_q - PHASE_W'(1);
    stretch_d   = stretch_q;
    sda_oe_d    = sda_oe_q;
    scl_oe_d    = scl_oe_q;
    done_d      = 1'b0;
    status_d    = status_q;
    busy_d      = busy_q;
    cmd_ready_d = cmd_ready_q;

    case (state_q)
      ST_IDLE: begin
        // The done cycle lands here with ready low; ready rises one cycle later.
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          busy_d      = 1'b1;
          cmd_ready_d = 1'b0;
          status_d    = STAT_OK;
          phase_d     = HP_LOAD;
          stretch_d   = '0;
          case (cmd)
            CMD_START: begin
              state_d  = ST_S0;
              sda_oe_d = 1'b0;
              scl_oe_d = 1'b0;
            end
            CMD_RESTART: begin
              state_d  = ST_R0;
              sda_oe_d = 1'b0;
              scl_oe_d = 1'b1;
            end
            CMD_STOP: begin
              state_d  = ST_P0;
              sda_oe_d = 1'b1;
              scl_oe_d = 1'b1;
            end
            default: state_d = ST_BAD;
          endcase
        end
      end

      // START: bus must be seen idle before pulling SDA then SCL low
      ST_S0: begin
        if (phase_end) begin
          if (!sda_s || !scl_s) begin
            state_d  = ST_IDLE;
            done_d   = 1'b1;
            status_d = STAT_ARB;
            sda_oe_d = 1'b0;
            scl_oe_d = 1'b0;
          end else begin
            state_d  = ST_S1;
            phase_d  = HP_LOAD;
            sda_oe_d = 1'b1;
          end
        end
      end
      ST_S1: begin
        if (phase_end) begin
          state_d  = ST_S2;
          phase_d  = HP_LOAD;
          scl_oe_d = 1'b1;
        end
      end
      ST_S2: begin
        if (phase_end) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          status_d = STAT_OK;
        end
      end

      // RESTART: release SDA with SCL low, then raise SCL
      ST_R0: begin
        if (phase_end) begin
          state_d   = ST_R1;
          scl_oe_d  = 1'b0;
          stretch_d = '0;
        end
      end

      // Wait for SCL high; a high SCL beats the timeout on the same cycle
      ST_R1, ST_P1: begin
        scl_oe_d = 1'b0;
        if (scl_s) begin
          state_d = (state_q == ST_R1) ? ST_R2 : ST_P2;
          phase_d = HP_LOAD;
        end else if (stretch_q == STR_LIMIT) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          status_d = STAT_TIMEOUT;
          sda_oe_d = 1'b0;
          scl_oe_d = 1'b0;
        end else begin
          stretch_d = stretch_q + STRETCH_W'(1);
        end
      end

      ST_R2: begin
        if (phase_end) begin
          if (!sda_s) begin
            state_d  = ST_IDLE;
            done_d   = 1'b1;
            status_d = STAT_ARB;
            sda_oe_d = 1'b0;
            scl_oe_d = 1'b0;
          end else begin
            state_d  = ST_R3;
            phase_d  = HP_LOAD;
            sda_oe_d = 1'b1;
          end
        end
      end
      ST_R3: begin
        if (phase_end) begin
          state_d  = ST_R4;
          phase_d  = HP_LOAD;
          scl_oe_d = 1'b1;
        end
      end
      ST_R4: begin
        if (phase_end) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          status_d = STAT_OK;
        end
      end

      // STOP: SDA low while SCL rises, then release SDA
      ST_P0: begin
        if (phase_end) begin
          state_d   = ST_P1;
          scl_oe_d  = 1'b0;
          stretch_d = '0;
        end
      end
      ST_P2: begin
        if (phase_end) begin
          state_d  = ST_P3;
          phase_d  = HP_LOAD;
          sda_oe_d = 1'b0;
        end
      end
      ST_P3: begin
        if (phase_end) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          if (!sda_s) begin
            status_d = STAT_ARB;
            sda_oe_d = 1'b0;
            scl_oe_d = 1'b0;
          end else begin
            status_d = STAT_OK;
          end
        end
      end

      ST_BAD: begin
        state_d  = ST_IDLE;
        done_d   = 1'b1;
        status_d = STAT_BAD;
      end

      default: begin
        state_d  = ST_IDLE;
        sda_oe_d = 1'b0;
        scl_oe_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      stretch_q   <= '0;
      sda_oe_q    <= 1'b0;
      scl_oe_q    <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= STAT_OK;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      stretch_q   <= stretch_d;
      sda_oe_q    <= sda_oe_d;
      scl_oe_q    <= scl_oe_d;
      done_q      <= done_d;
      status_q    <= status_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign done      = done_q;
  assign status    = status_q;
  assign busy      = busy_q;
  assign sda_oe    = sda_oe_q;
  assign scl_oe    = scl_oe_q;

endmodule

// File: tb/tb_i2c_master_bus_condition.sv
// Directed bench for i2c_master_bus_condition with HALF_PERIOD=4 and
// STRETCH_TIMEOUT=20; pads are modelled as pulled-up open-drain lines.
module tb_i2c_master_bus_condition;

  localparam int unsigned HP = 4;
  localparam int unsigned TO = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd = 2'b00;
  logic       done;
  logic [1:0] status;
  logic       busy;
  logic       sda_in, scl_in;
  logic       sda_oe, scl_oe;
  logic       sda_force = 1'b0;
  logic       scl_hold = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations recorded by run_cmd
  int         lat, t_sda_set, t_scl_set, t_scl_clr;
  logic       oe0_sda, oe0_scl;
  logic [1:0] st_done;
  logic       sda_done, scl_done, busy_done, rdy_done;

  assign sda_in = ~sda_oe & ~sda_force;
  assign scl_in = ~scl_oe & ~scl_hold;

  always #5 clk = ~clk;

  i2c_master_bus_condition #(
    .HALF_PERIOD    (HP),
    .STRETCH_TIMEOUT(TO),
    .FILTER_LEN     (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd      (cmd),
    .done     (done),
    .status   (status),
    .busy     (busy),
    .sda_in   (sda_in),
    .scl_in   (scl_in),
    .sda_oe   (sda_oe),
    .scl_oe   (scl_oe)
  );

  // Issue one command; cycle k = k-th rising edge after the accept edge.
  task automatic run_cmd(input logic [1:0] c, input int hold_rel, input int force_at);
    int   k;
    logic ps, pc;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_wait: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd       = c;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    oe0_sda   = sda_oe;
    oe0_scl   = scl_oe;
    ps        = sda_oe;
    pc        = scl_oe;
    lat = -1; t_sda_set = -1; t_scl_set = -1; t_scl_clr = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (i == hold_rel) scl_hold = 1'b0;
      if (i == force_at) sda_force = 1'b1;
      if (sda_oe === 1'b1 && ps === 1'b0 && t_sda_set < 0) t_sda_set = i;
      if (scl_oe === 1'b1 && pc === 1'b0 && t_scl_set < 0) t_scl_set = i;
      if (scl_oe === 1'b0 && pc === 1'b1 && t_scl_clr < 0) t_scl_clr = i;
      ps = sda_oe;
      pc = scl_oe;
      if (done === 1'b1) begin
        lat       = i;
        st_done   = status;
        sda_done  = sda_oe;
        scl_done  = scl_oe;
        busy_done = busy;
        rdy_done  = cmd_ready;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b required 0", sda_oe); end
    n_tests++; if (scl_oe !== 1'b0) begin n_fail++; $display("FAIL reset_scl_oe: got %b required 0", scl_oe); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
    n_tests++; if (status !== 2'b00) begin n_fail++; $display("FAIL reset_status: got %b required 00", status); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
  endtask

  task automatic test_start();
    run_cmd(2'b00, 0, 0);
    n_tests++; if (t_sda_set !== 4) begin n_fail++; $display("FAIL start_sda_fall: cycle %0d required 4", t_sda_set); end
    n_tests++; if (t_scl_set !== 8) begin n_fail++; $display("FAIL start_scl_fall: cycle %0d required 8", t_scl_set); end
    n_tests++; if (lat !== 12) begin n_fail++; $display("FAIL start_latency: got %0d required 12", lat); end
    n_tests++; if (st_done !== 2'b00) begin n_fail++; $display("FAIL start_status: got %b required 00", st_done); end
    n_tests++; if ({sda_done, scl_done} !== 2'b11) begin n_fail++; $display("FAIL start_lines: got %b required 11", {sda_done, scl_done}); end
    n_tests++; if ({busy_done, rdy_done} !== 2'b10) begin n_fail++; $display("FAIL start_busy_ready_at_done: got %b required 10", {busy_done, rdy_done}); end
    @(negedge clk);
    @(negedge clk);
    n_tests++; if ({cmd_ready, busy, done} !== 3'b100) begin n_fail++; $display("FAIL start_after_done: ready/busy/done %b required 100", {cmd_ready, busy, done}); end
  endtask

  task automatic test_restart();
    run_cmd(2'b01, 0, 0);
    n_tests++; if ({oe0_sda, oe0_scl} !== 2'b01) begin n_fail++; $display("FAIL restart_entry: sda/scl oe %b required 01", {oe0_sda, oe0_scl}); end
    n_tests++; if (t_scl_clr !== 4) begin n_fail++; $display("FAIL restart_scl_release: cycle %0d required 4", t_scl_clr); end
    n_tests++; if (t_sda_set !== 11) begin n_fail++; $display("FAIL restart_sda_fall: cycle %0d required 11", t_sda_set); end
    n_tests++; if (t_scl_set !== 15) begin n_fail++; $display("FAIL restart_scl_fall: cycle %0d required 15", t_scl_set); end
    n_tests++; if (lat !== 19) begin n_fail++; $display("FAIL restart_latency: got %0d required 19", lat); end
    n_tests++; if (st_done !== 2'b00) begin n_fail++; $display("FAIL restart_status: got %b required 00", st_done); end
  endtask

  task automatic test_stop_stretch();
    scl_hold = 1'b1;
    run_cmd(2'b10, 14, 0);
    scl_hold = 1'b0;
    n_tests++; if (lat !== 25) begin n_fail++; $display("FAIL stop_stretch_latency: got %0d required 25", lat); end
    n_tests++; if (st_done !== 2'b00) begin n_fail++; $display("FAIL stop_stretch_status: got %b required 00", st_done); end
    n_tests++; if ({sda_done, scl_done} !== 2'b00) begin n_fail++; $display("FAIL stop_stretch_lines: got %b required 00", {sda_done, scl_done}); end
  endtask

  task automatic test_stretch_timeout();
    scl_hold = 1'b1;
    run_cmd(2'b10, 0, 0);
    scl_hold = 1'b0;
    n_tests++; if (lat !== 24) begin n_fail++; $display("FAIL timeout_latency: got %0d required 24", lat); end
    n_tests++; if (st_done !== 2'b01) begin n_fail++; $display("FAIL timeout_status: got %b required 01", st_done); end
    n_tests++; if ({sda_done, scl_done} !== 2'b00) begin n_fail++; $display("FAIL timeout_lines: got %b required 00", {sda_done, scl_done}); end
  endtask

  task automatic test_arb_lost();
    run_cmd(2'b01, 0, 7);
    sda_force = 1'b0;
    n_tests++; if (lat !== 11) begin n_fail++; $display("FAIL arb_latency: got %0d required 11", lat); end
    n_tests++; if (st_done !== 2'b10) begin n_fail++; $display("FAIL arb_status: got %b required 10", st_done); end
    n_tests++; if ({sda_done, scl_done} !== 2'b00) begin n_fail++; $display("FAIL arb_lines: got %b required 00", {sda_done, scl_done}); end
  endtask

  task automatic test_bad_cmd();
    run_cmd(2'b00, 0, 0);
    n_tests++; if (lat !== 12) begin n_fail++; $display("FAIL bad_pre_start_latency: got %0d required 12", lat); end
    run_cmd(2'b11, 0, 0);
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL bad_latency: got %0d required 1", lat); end
    n_tests++; if (st_done !== 2'b11) begin n_fail++; $display("FAIL bad_status: got %b required 11", st_done); end
    n_tests++; if ({sda_done, scl_done} !== 2'b11) begin n_fail++; $display("FAIL bad_lines_kept: got %b required 11", {sda_done, scl_done}); end
  endtask

  task automatic test_back_to_back();
    int k, ndone, first, second;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    ndone = 0; first = -1; second = -1;
    cmd_valid = 1'b1;
    cmd       = 2'b10;
    @(posedge clk);
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) first = i;
        else begin
          second    = i;
          cmd_valid = 1'b0;
          break;
        end
      end
    end
    cmd_valid = 1'b0;
    n_tests++; if (first !== 15) begin n_fail++; $display("FAIL b2b_first_done: cycle %0d required 15", first); end
    n_tests++; if (second !== 32) begin n_fail++; $display("FAIL b2b_second_done: cycle %0d required 32", second); end
    n_tests++; if (ndone !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d required 2", ndone); end
  endtask

  task automatic test_reset_mid();
    int k;
    logic saw_done;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    cmd_valid = 1'b1;
    cmd       = 2'b01;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    n_tests++; if ({sda_oe, scl_oe, busy} !== 3'b101) begin n_fail++; $display("FAIL mid_r3_state: sda/scl/busy %b required 101", {sda_oe, scl_oe, busy}); end
    rst_n = 1'b0;
    #1;
    n_tests++; if ({sda_oe, scl_oe} !== 2'b00) begin n_fail++; $display("FAIL mid_reset_lines: got %b required 00", {sda_oe, scl_oe}); end
    n_tests++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL mid_reset_busy_done: got %b required 00", {busy, done}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    n_tests++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_no_done: saw_done=%b required 0", saw_done); end
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b required 1", cmd_ready); end
    run_cmd(2'b00, 0, 0);
    n_tests++; if (lat !== 12) begin n_fail++; $display("FAIL post_reset_start_latency: got %0d required 12", lat); end
    n_tests++; if (st_done !== 2'b00) begin n_fail++; $display("FAIL post_reset_start_status: got %b required 00", st_done); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_restart();
    test_stop_stretch();
    test_stretch_timeout();
    test_arb_lost();
    test_bad_cmd();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
